// File: rtl/instr_reg_sched.sv
// Round-robin front end for a shared instr_register: accepts one request,
// writes it, reads the stored word back and returns the result.
package instr_register_pkg;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0] address_t;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    operand_t rslt;
  } instruction_t;
endpackage

module instr_reg_sched
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  opcode_t            req_opcode    [2],
  input  operand_t           req_operand_a [2],
  input  operand_t           req_operand_b [2],
  output logic               load_en,
  output address_t           write_pointer,
  output address_t           read_pointer,
  output opcode_t            opcode,
  output operand_t           operand_a,
  output operand_t           operand_b,
  input  instruction_t       instruction_word,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output address_t           rsp_addr,
  output operand_t           rsp_result,
  output logic               rsp_error,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_win;
  logic             w_accept;
  logic             w_rsp_fire;
  logic             r_prio;
  address_t         r_wp;
  logic             r_load_en;
  address_t         r_write_pointer;
  address_t         r_read_pointer;
  opcode_t          r_opcode;
  operand_t         r_operand_a;
  operand_t         r_operand_b;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  address_t         r_rsp_addr;
  operand_t         r_rsp_result;
  logic             r_rsp_error;
  logic             r_busy;
  logic [CNT_W-1:0] r_op_count;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration, next state and the combinational accept strobe
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    w_accept    = 1'b0;
    w_rsp_fire  = 1'b0;
    if (req_valid[r_prio]) begin
      w_win = r_prio;
    end else begin
      w_win = ~r_prio;
    end
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready[w_win] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = ST_WRITE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: w_state_nxt = ST_READ;
      ST_READ:  w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: the issued fields double as the hold registers for the readback compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio          <= 1'b0;
      r_wp            <= 5'd0;
      r_load_en       <= 1'b0;
      r_write_pointer <= 5'd0;
      r_read_pointer  <= 5'd0;
      r_opcode        <= ZERO;
      r_operand_a     <= 32'sd0;
      r_operand_b     <= 32'sd0;
      r_rsp_valid     <= 1'b0;
      r_rsp_id        <= 1'b0;
      r_rsp_addr      <= 5'd0;
      r_rsp_result    <= 32'sd0;
      r_rsp_error     <= 1'b0;
      r_busy          <= 1'b0;
      r_op_count      <= {CNT_W{1'b0}};
    end else begin
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_load_en <= w_accept;
      if (w_accept) begin
        r_opcode        <= req_opcode[w_win];
        r_operand_a     <= req_operand_a[w_win];
        r_operand_b     <= req_operand_b[w_win];
        r_write_pointer <= r_wp;
        r_rsp_id        <= w_win;
      end
      if (r_state == ST_WRITE) begin
        r_read_pointer <= r_wp;
      end
      if (r_state == ST_READ) begin
        r_rsp_result <= instruction_word.rslt;
        r_rsp_error  <= (instruction_word.opc  != r_opcode)    ||
                        (instruction_word.op_a != r_operand_a) ||
                        (instruction_word.op_b != r_operand_b);
        r_rsp_addr   <= r_wp;
        r_rsp_valid  <= 1'b1;
      end
      if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
        r_prio      <= ~r_rsp_id;
        r_wp        <= (r_wp == address_t'(DEPTH - 1)) ? 5'd0 : r_wp + 5'd1;
        if (r_op_count != {CNT_W{1'b1}}) begin
          r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign load_en       = r_load_en;
  assign write_pointer = r_write_pointer;
  assign read_pointer  = r_read_pointer;
  assign opcode        = r_opcode;
  assign operand_a     = r_operand_a;
  assign operand_b     = r_operand_b;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_rsp_id;
  assign rsp_addr      = r_rsp_addr;
  assign rsp_result    = r_rsp_result;
  assign rsp_error     = r_rsp_error;
  assign busy          = r_busy;
  assign op_count      = r_op_count;

endmodule

// File: tb/tb_instr_reg_sched.sv
// Directed bench for instr_reg_sched with a behavioural instr_register
// (optionally corrupting writes the way a FORCE_LOAD_ERROR build does).
module tb_instr_reg_sched;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  opcode_t      req_opcode    [2];
  operand_t     req_operand_a [2];
  operand_t     req_operand_b [2];
  logic         load_en;
  address_t     write_pointer;
  address_t     read_pointer;
  opcode_t      opcode;
  operand_t     operand_a;
  operand_t     operand_b;
  instruction_t instruction_word;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  address_t     rsp_addr;
  operand_t     rsp_result;
  logic         rsp_error;
  logic         busy;
  logic [15:0]  op_count;

  int total = 0;
  int fails = 0;
  logic force_err = 1'b0;
  instruction_t mem [32];

  instr_reg_sched #(.DEPTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .load_en(load_en), .write_pointer(write_pointer), .read_pointer(read_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .instruction_word(instruction_word), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_addr(rsp_addr), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic operand_t alu(input opcode_t op, input operand_t a, input operand_t b);
    case (op)
      ZERO:    return 32'sd0;
      PASSA:   return a;
      PASSB:   return b;
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return a * b;
      DIV:     return (b == 32'sd0) ? 32'sd0 : a / b;
      MOD:     return (b == 32'sd0) ? 32'sd0 : a % b;
      default: return 32'sd0;
    endcase
  endfunction

  // Behavioural register file; the error build stores op_a in place of op_b
  always @(posedge clk) begin
    if (load_en) begin
      if (force_err) begin
        mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_a,
                                rslt: alu(opcode, operand_a, operand_a)};
      end else begin
        mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                                rslt: alu(opcode, operand_a, operand_b)};
      end
    end
  end
  assign instruction_word = mem[read_pointer];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // One full transaction; hold>0 keeps rsp_ready low for that many RESP cycles
  task automatic do_op(input logic id, input opcode_t op, input operand_t a, input operand_t b,
                       input operand_t exp_res, input int exp_addr, input logic exp_err,
                       input int hold);
    int n;
    rsp_ready         = (hold == 0);
    req_opcode[id]    = op;
    req_operand_a[id] = a;
    req_operand_b[id] = b;
    req_valid[id]     = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      tick();
      n++;
    end
    check("accept", 32'(req_ready), id ? 32'd2 : 32'd1);
    tick();
    req_valid[id] = 1'b0;
    check("wr_load_en", 32'(load_en), 32'd1);
    check("wr_ptr", 32'(write_pointer), 32'(exp_addr));
    check("wr_opcode", 32'(opcode), 32'(op));
    check("wr_ready_low", 32'(req_ready), 32'd0);
    check("busy", 32'(busy), 32'd1);
    tick();
    check("rd_load_en", 32'(load_en), 32'd0);
    check("rd_ptr", 32'(read_pointer), 32'(exp_addr));
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_addr", 32'(rsp_addr), 32'(exp_addr));
    check("rsp_result", 32'(rsp_result), 32'(exp_res));
    check("rsp_error", 32'(rsp_error), 32'(exp_err));
    if (hold > 0) begin
      req_valid = 2'b11;
      for (int h = 0; h < hold; h++) begin
        tick();
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_result", 32'(rsp_result), 32'(exp_res));
        check("hold_addr", 32'(rsp_addr), 32'(exp_addr));
        check("hold_ready", 32'(req_ready), 32'd0);
        check("hold_load_en", 32'(load_en), 32'd0);
      end
      req_valid = 2'b00;
    end
    rsp_ready = 1'b1;
    tick();
    check("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int k;
    reset_n   = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_opcode[i]    = ZERO;
      req_operand_a[i] = 32'sd0;
      req_operand_b[i] = 32'sd0;
    end
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_load_en", 32'(load_en), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wp", 32'(write_pointer), 32'd0);

    do_op(1'b0, ADD, 32'sd5, 32'sd3, 32'sd8, 0, 1'b0, 0);
    check("cnt_after_first", 32'(op_count), 32'd1);

    // Both requesters continuously valid: strict alternation from requester 0
    do_reset();
    req_opcode[0] = SUB;  req_operand_a[0] = 32'sd10; req_operand_b[0] = 32'sd4;
    req_opcode[1] = MULT; req_operand_a[1] = 32'sd6;  req_operand_b[1] = 32'sd7;
    req_valid = 2'b11;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      if (rsp_valid) begin
        check("alt_id", 32'(rsp_id), 32'(k % 2));
        check("alt_result", 32'(rsp_result), (k % 2 == 1) ? 32'd42 : 32'd6);
        check("alt_addr", 32'(rsp_addr), 32'(k));
        k++;
      end
      check("alt_one_hot", 32'(req_ready == 2'b11), 32'd0);
      tick();
    end
    req_valid = 2'b00;
    check("alt_count", 32'(k), 32'd4);

    // Pointer wrap across 33 back-to-back requests
    do_reset();
    for (int i = 0; i < 33; i++) begin
      do_op(1'b0, PASSA, operand_t'(i), 32'sd0, operand_t'(i), i % 32, 1'b0, 0);
    end
    check("wrap_op_count", 32'(op_count), 32'd33);

    // Backpressure on the response channel
    do_op(1'b0, ADD, 32'sd7, 32'sd8, 32'sd15, 1, 1'b0, 5);
    check("bp_op_count", 32'(op_count), 32'd34);

    // Reset during READ abandons the operation
    req_opcode[0] = DIV; req_operand_a[0] = 32'sd20; req_operand_b[0] = 32'sd4;
    req_valid = 2'b01;
    #1;
    check("abort_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    check("abort_in_read", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_op_count", 32'(op_count), 32'd0);
    tick();
    tick();
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    reset_n = 1'b1;
    do_op(1'b0, DIV, 32'sd20, 32'sd4, 32'sd5, 0, 1'b0, 0);
    check("abort_op_count_after", 32'(op_count), 32'd1);

    // Corrupting register: readback mismatch flagged
    force_err = 1'b1;
    do_op(1'b0, ADD, 32'sd2, 32'sd9, 32'sd4, 1, 1'b1, 0);
    force_err = 1'b0;
    check("err_op_count", 32'(op_count), 32'd2);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_reg_sched.md
Name: instr_reg_sched

Overview:
- Two-requester round-robin scheduler that shares one instr_register instance.
- For each accepted request it performs four steps in order: accept, write into instr_register, read back the stored word, return the result on a response channel.
- Owns load_en, write_pointer and read_pointer; write_pointer auto-increments and wraps across the register array.
- Sits between the two stimulus/requester agents and the instr_register DUT.

Parameters:
- DEPTH, 32, number of instr_register entries; write_pointer wraps at DEPTH-1.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock
- reset_n  input  1  async active-low reset
- req_valid  input  2  per-requester request valid (index 0, 1)
- req_ready  output  2  per-requester accept; at most one bit high
- req_opcode  input  2 x opcode_t  requested opcode per requester
- req_operand_a  input  2 x operand_t  operand a per requester
- req_operand_b  input  2 x operand_t  operand b per requester
- load_en  output  1  to instr_register
- write_pointer  output  address_t  to instr_register
- read_pointer  output  address_t  to instr_register
- opcode  output  opcode_t  to instr_register
- operand_a  output  operand_t  to instr_register
- operand_b  output  operand_t  to instr_register
- instruction_word  input  instruction_t  from instr_register (opc, op_a, op_b, rslt)
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_id  output  1  requester index of the response
- rsp_addr  output  address_t  entry written
- rsp_result  output  operand_t  rslt field read back
- rsp_error  output  1  readback opc/op_a/op_b differs from the values issued
- busy  output  1  FSM not in IDLE
- op_count  output  CNT_W  completed responses; saturates at all-ones

Behaviour:
- Types come from instr_register_pkg: operand_t signed 32b, opcode_t 4b enum, address_t 5b.
- Reset (async, reset_n low): state=IDLE, wp=0, priority pointer=0 (requester 0 favoured), all outputs 0, op_count=0. Reset mid-operation abandons the operation; no response is produced.
- FSM IDLE -> WRITE -> READ -> RESP -> IDLE.
- IDLE:
  - If any req_valid, pick a winner round-robin: the favoured requester if its valid is set, else the other.
  - req_ready[winner]=1 combinationally in this cycle only; capture opcode/operands into hold registers; go WRITE.
  - No valid: stay IDLE, req_ready=0.
- WRITE: load_en=1 for exactly one cycle; write_pointer=wp; opcode/operand outputs = hold registers; go READ.
- READ:
  - read_pointer=wp; sample instruction_word at the clock edge.
  - rsp_result <= rslt.
  - rsp_error <= (opc!=held opcode) or (op_a!=held a) or (op_b!=held b).
  - Go RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_addr, rsp_result, rsp_error held stable until accepted.
  - On rsp_ready: wp <= (wp==DEPTH-1) ? 0 : wp+1; favoured requester <= other than winner; op_count++ (saturating); go IDLE.
- Outside WRITE: load_en=0; opcode/operand outputs hold their last values; read_pointer holds its last value.
- Latency: acceptance edge to rsp_valid high = 3 cycles. Minimum issue interval = 4 cycles with rsp_ready held high.
- Requesters keep valid/data stable until ready; req_ready never depends on rsp_ready.
- Simultaneous valid on both requesters: the favoured one wins; the other is served next (strict alternation under continuous load).
- rsp_error is informational only; it does not stall or retry.

Test Plan:
- Reset, then req0 ADD a=5 b=3 -> req_ready[0] high 1 cycle; load_en high 1 cycle with write_pointer=0; rsp_valid 3 cycles after accept with rsp_result=8, rsp_id=0, rsp_addr=0, rsp_error=0.
- Both valid continuously (req0 SUB 10,4; req1 MULT 6,7) -> responses alternate id 0,1,0,1 with results 6, 42, 6, 42; addresses 0,1,2,3.
- 33 back-to-back req0 PASSA a=i -> addresses 0..31 then 0 (wrap); final rsp_result=32; op_count=33.
- Hold rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, no new req_ready, load_en=0; release -> completes normally.
- Drive reset_n low during READ of DIV 20,4 -> no response; wp=0; op_count=0; next request writes address 0 and returns 5.
- Compile instr_register with FORCE_LOAD_ERROR; req0 ADD a=2 b=9 -> rsp_error=1, rsp_result=4.
